// File: rtl/address_generator_mc.sv
// Multi-channel BRAM address generator: one shared word counter, per-channel delayed byte addresses.
// Optional ADDR_GEN_DECIMATE_EN adds a decim port that slows the counter to one step every decim+1 cycles.
module address_generator_mc #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_CH  = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [31:0]                  cfg,
   input  logic [31:0]                  period,
   input  logic [N_CH*WIDTH-1:0]        delay,
`ifdef ADDR_GEN_DECIMATE_EN
   input  logic [15:0]                  decim,
`endif
   output logic [N_CH*(WIDTH+2)-1:0]    addr,
   output logic                         tvalid,
   output logic                         restart,
   output logic                         wrap
);

   localparam int unsigned AW = WIDTH + 2;
   localparam int unsigned SW = WIDTH + 1;
   localparam logic [WIDTH-1:0] PMAX = '1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  count, count_nx;
   logic [WIDTH-1:0]  pshad, pshad_nx;
   logic              first, first_nx;
   logic              cfg1_q;
   logic              rise;
   logic              tick;
   logic [WIDTH-1:0]  pclamp;

   // Stage 1: counter value captured with its flags and the period it belongs to
   logic              v1, r1, w1;
   logic [WIDTH-1:0]  c1, p1;
   logic [N_CH*AW-1:0] addr_nx;

   logic unused_cfg;
   assign unused_cfg = ^cfg[31:3];

   assign rise   = cfg[1] & ~cfg1_q;
   assign pclamp = (period > 32'(PMAX)) ? PMAX : period[WIDTH-1:0];

`ifdef ADDR_GEN_DECIMATE_EN
   logic [15:0] dcnt, dcnt_nx, dshad, dshad_nx;
   assign tick = (dcnt == 16'd0);

   // Decimation phase counter; its length is resampled at each wrap
   always_comb begin
      dcnt_nx  = dcnt;
      dshad_nx = dshad;
      case (state)
         IDLE: begin
            dcnt_nx = '0;
            if (cfg[0]) dshad_nx = decim;
         end
         RUN: begin
            if (tick && count == pshad) begin
               dshad_nx = decim;
               dcnt_nx  = (decim == 16'd0) ? 16'd0 : 16'd1;
            end else begin
               dcnt_nx  = (dcnt >= dshad) ? 16'd0 : dcnt + 16'd1;
            end
            if (rise) dcnt_nx = '0;
         end
         default: dcnt_nx = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt  <= '0;
         dshad <= '0;
      end else begin
         dcnt  <= dcnt_nx;
         dshad <= dshad_nx;
      end
   end
`else
   assign tick = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         pshad  <= PMAX;
         first  <= 1'b0;
         cfg1_q <= 1'b0;
      end else begin
         state  <= state_nx;
         count  <= count_nx;
         pshad  <= pshad_nx;
         first  <= first_nx;
         cfg1_q <= cfg[1];
      end
   end

   always_comb begin
      state_nx = state;
      count_nx = count;
      pshad_nx = pshad;
      first_nx = first;
      case (state)
         IDLE: begin
            count_nx = '0;
            first_nx = 1'b1;
            if (cfg[0]) begin
               state_nx = RUN;
               pshad_nx = pclamp;
            end
         end
         RUN: begin
            if (tick && count == pshad) pshad_nx = pclamp;
            if (!cfg[0]) begin
               state_nx = IDLE;
            end else if (rise) begin
               count_nx = '0;
               first_nx = 1'b1;
            end else if (tick) begin
               first_nx = 1'b0;
               if (count == pshad) begin
                  count_nx = '0;
                  if (cfg[2]) state_nx = DONE;
               end else begin
                  count_nx = count + WIDTH'(1);
               end
            end
         end
         DONE: begin
            if (!cfg[0]) begin
               state_nx = IDLE;
            end else if (rise) begin
               state_nx = RUN;
               count_nx = '0;
               first_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1 <= 1'b0;
         r1 <= 1'b0;
         w1 <= 1'b0;
         c1 <= '0;
         p1 <= '0;
      end else begin
         v1 <= (state == RUN) && tick;
         r1 <= first;
         w1 <= (count == pshad);
         c1 <= count;
         p1 <= pshad;
      end
   end

   // Stage 2: per-channel modular add of the (pre-reduced) delay
   always_comb begin
      logic [SW-1:0] pw, d, s;
      pw      = {1'b0, p1} + SW'(1);
      d       = '0;
      s       = '0;
      addr_nx = '0;
      for (int k = 0; k < N_CH; k++) begin
         d = {1'b0, delay[k*WIDTH +: WIDTH]};
         if (d > {1'b0, p1}) d = d - pw;
         s = {1'b0, c1} + d;
         if (s > {1'b0, p1}) s = s - pw;
         addr_nx[k*AW +: AW] = {s[WIDTH-1:0], 2'b00};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr    <= '0;
         tvalid  <= 1'b0;
         restart <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         if (v1) addr <= addr_nx;
         tvalid  <= v1;
         restart <= v1 & r1;
         wrap    <= v1 & w1;
      end
   end

endmodule
